// File: rtl/instruction_fetch_unit_if.sv
// Program-memory fetch bus: request/grant issue phase, in-order rvalid response phase.
// Valid/ready semantics: a fetch is issued on the rising edge where PM_Req && PM_Gnt; each
// PM_Rvalid pulse returns exactly one word, in issue order, no earlier than the next cycle.
interface instruction_fetch_unit_if;
  logic        PM_Req;
  logic [31:0] PM_Addr;
  logic        PM_Gnt;
  logic        PM_Rvalid;
  logic [31:0] PM_Rdata;

  modport master (output PM_Req, PM_Addr, input PM_Gnt, PM_Rvalid, PM_Rdata);
  modport slave  (input PM_Req, PM_Addr, output PM_Gnt, PM_Rvalid, PM_Rdata);
endinterface

// File: rtl/instruction_fetch_unit.sv
// IF stage: issues word fetches, queues returned instructions with their PCs and
// presents them to IF/ID, handling ID stall, redirect flush and misaligned-redirect halt.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic                             Clk,
  input  logic                             Reset_n,
  input  logic                             Stall_ID,
  input  logic                             Flush,
  input  logic [31:0]                      Redirect_PC,
  instruction_fetch_unit_if.master         pm,
  output logic [31:0]                      Instruction_Fetch_IF_PM,
  output logic [31:0]                      PC_IF,
  output logic                             Valid_IF,
  output logic                             Misaligned_IF,
  output logic [1:0]                       State_Dbg
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_S = (CW+1)'(QUEUE_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HALT = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] outst_q, outst_d, drop_q, drop_d;
  logic [AW:0]   q_wp_q, q_wp_d, q_rp_q, q_rp_d;
  logic [AW:0]   af_wp_q, af_wp_d, af_rp_q, af_rp_d;
  logic          misal_q, misal_d;

  logic [31:0]   q_instr_q [QUEUE_DEPTH];
  logic [31:0]   q_pc_q    [QUEUE_DEPTH];
  logic [31:0]   af_q      [QUEUE_DEPTH];

  logic [CW-1:0] occ;
  logic [CW:0]   sum;
  logic          empty, req, issue, rsp_acc, rsp_keep, push, pop, valid;

  always_comb begin
    empty    = (q_wp_q == q_rp_q);
    occ      = q_wp_q - q_rp_q;
    sum      = {1'b0, outst_q} + {1'b0, occ};
    req      = (state_q == FETCH) && !Flush && (sum < DEPTH_S);
    issue    = req && pm.PM_Gnt;
    // A response with nothing outstanding (e.g. one left over from before reset) is ignored.
    rsp_acc  = pm.PM_Rvalid && (outst_q != '0);
    rsp_keep = rsp_acc && (drop_q == '0);
    valid    = !empty && !Flush;
    pop      = valid && !Stall_ID;
    push     = rsp_keep && !Flush;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    outst_d = outst_q;
    drop_d  = drop_q;
    q_wp_d  = q_wp_q;
    q_rp_d  = q_rp_q;
    af_wp_d = af_wp_q;
    af_rp_d = af_rp_q;
    misal_d = misal_q;
    unique case ({issue, rsp_acc})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase
    if (Flush) begin
      // Everything still in flight after this edge belongs to the old path.
      drop_d  = outst_q - CW'(rsp_acc);
      pc_d    = Redirect_PC;
      q_wp_d  = '0;
      q_rp_d  = '0;
      af_wp_d = '0;
      af_rp_d = '0;
      if (Redirect_PC[1:0] != 2'b00) begin
        state_d = HALT;
        misal_d = 1'b1;
      end else begin
        state_d = FETCH;
        misal_d = 1'b0;
      end
    end else begin
      if (rsp_acc && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (issue) pc_d = pc_q + 32'd4;
      q_wp_d  = q_wp_q + (AW+1)'(push);
      q_rp_d  = q_rp_q + (AW+1)'(pop);
      af_wp_d = af_wp_q + (AW+1)'(issue);
      af_rp_d = af_rp_q + (AW+1)'(rsp_keep);
      if (state_q == IDLE) state_d = FETCH;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
      q_wp_q  <= '0;
      q_rp_q  <= '0;
      af_wp_q <= '0;
      af_rp_q <= '0;
      misal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      q_wp_q  <= q_wp_d;
      q_rp_q  <= q_rp_d;
      af_wp_q <= af_wp_d;
      af_rp_q <= af_rp_d;
      misal_q <= misal_d;
    end
  end

  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge Clk) begin
    if (issue) af_q[af_wp_q[AW-1:0]] <= pc_q;
    if (push) begin
      q_instr_q[q_wp_q[AW-1:0]] <= pm.PM_Rdata;
      q_pc_q[q_wp_q[AW-1:0]]    <= af_q[af_rp_q[AW-1:0]];
    end
  end

  assign pm.PM_Req               = req;
  assign pm.PM_Addr              = pc_q;
  assign Valid_IF                = valid;
  assign Instruction_Fetch_IF_PM = valid ? q_instr_q[q_rp_q[AW-1:0]] : NOP_INSTR;
  assign PC_IF                   = empty ? 32'h0 : q_pc_q[q_rp_q[AW-1:0]];
  assign Misaligned_IF           = misal_q;
  assign State_Dbg               = state_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: in-order memory responder, PC/instruction
// scoreboard tracking the expected next PC, and directed checks for each scenario.
module tb_instruction_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Stall_ID = 1'b0;
  logic        Flush = 1'b0;
  logic [31:0] Redirect_PC = 32'h0;
  logic [31:0] Instruction_Fetch_IF_PM, PC_IF;
  logic        Valid_IF, Misaligned_IF;
  logic [1:0]  State_Dbg;

  instruction_fetch_unit_if pm ();

  instruction_fetch_unit dut (
    .Clk                     (Clk),
    .Reset_n                 (Reset_n),
    .Stall_ID                (Stall_ID),
    .Flush                   (Flush),
    .Redirect_PC             (Redirect_PC),
    .pm                      (pm),
    .Instruction_Fetch_IF_PM (Instruction_Fetch_IF_PM),
    .PC_IF                   (PC_IF),
    .Valid_IF                (Valid_IF),
    .Misaligned_IF           (Misaligned_IF),
    .State_Dbg               (State_Dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pops  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // ---------------- memory responder ----------------
  logic [31:0] exp_q[$];
  int          pend_due[$];
  int          cyc = 0;
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          gnt_rand = 1'b0;

  always begin
    int due;
    @(negedge Clk);
    cyc++;
    pm.PM_Rvalid = 1'b0;
    pm.PM_Rdata  = 32'h0;
    if (Reset_n && exp_q.size() > 0 && pend_due[0] <= cyc) begin
      pm.PM_Rvalid = 1'b1;
      pm.PM_Rdata  = mem_fn(exp_q.pop_front());
      void'(pend_due.pop_front());
    end
    pm.PM_Gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    if (Reset_n && pm.PM_Req && pm.PM_Gnt) begin
      due = cyc + int'($urandom_range(lat_min, lat_max));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      exp_q.push_back(pm.PM_Addr);
      pend_due.push_back(due);
    end
  end

  // ---------------- scoreboard: expected PC stream ----------------
  logic [31:0] exp_pc = 32'h0;

  always begin
    @(negedge Clk);
    #2;
    if (!Reset_n) begin
      exp_pc = 32'h0;
    end else if (Flush) begin
      check("flush_bubble", Instruction_Fetch_IF_PM, NOP);
      exp_pc = Redirect_PC;
    end else if (Valid_IF) begin
      check("sb_pc", PC_IF, exp_pc);
      check("sb_instr", Instruction_Fetch_IF_PM, mem_fn(exp_pc));
      if (!Stall_ID) begin
        exp_pc = exp_pc + 32'd4;
        n_pops++;
      end
    end else begin
      check("bubble_nop", Instruction_Fetch_IF_PM, NOP);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic sample();
    @(negedge Clk);
    #3;
  endtask

  task automatic flush_to(input logic [31:0] a);
    tick();
    Flush = 1'b1;
    Redirect_PC = a;
    tick();
    Flush = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      sample();
      if (Valid_IF) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_req(input string tag, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      sample();
      if (pm.PM_Req) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit ok;
    repeat (3) sample();
    check("rst_req", 32'(pm.PM_Req), 32'd0);
    check("rst_valid", 32'(Valid_IF), 32'd0);
    check("rst_instr", Instruction_Fetch_IF_PM, NOP);
    check("rst_pc", PC_IF, 32'h0);
    check("rst_misal", 32'(Misaligned_IF), 32'd0);
    check("rst_state", 32'(State_Dbg), 32'd0);

    // Release: one IDLE cycle, then fetch 0x0, 0x4; first instruction two cycles later.
    tick();
    Reset_n = 1'b1;
    sample();
    check("idle_req", 32'(pm.PM_Req), 32'd0);
    sample();
    check("fetch_state", 32'(State_Dbg), 32'd1);
    check("req0", 32'(pm.PM_Req), 32'd1);
    check("addr0", pm.PM_Addr, 32'h0);
    check("valid_c1", 32'(Valid_IF), 32'd0);
    sample();
    check("addr1", pm.PM_Addr, 32'h4);
    check("valid_c2", 32'(Valid_IF), 32'd0);
    sample();
    check("first_valid", 32'(Valid_IF), 32'd1);
    check("first_pc", PC_IF, 32'h0);
    repeat (10) sample();

    // Stall: queue fills, requests stop, outputs hold (scoreboard checks PC does not advance).
    tick();
    Stall_ID = 1'b1;
    repeat (5) sample();
    check("stall_req_off", 32'(pm.PM_Req), 32'd0);
    check("stall_valid", 32'(Valid_IF), 32'd1);
    tick();
    Stall_ID = 1'b0;
    repeat (8) sample();

    // Flush with two fetches in flight: their responses must be dropped.
    lat_min = 4;
    lat_max = 4;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      sample();
      if (!pm.PM_Req && exp_q.size() == 2 && !pm.PM_Rvalid) begin
        ok = 1'b1;
        break;
      end
    end
    check("two_outstanding", 32'(ok), 32'd1);
    flush_to(32'h100);
    wait_valid("redirect_valid", 40);
    check("redirect_pc", PC_IF, 32'h100);
    check("redirect_instr", Instruction_Fetch_IF_PM, mem_fn(32'h100));
    lat_min = 1;
    lat_max = 1;
    repeat (6) sample();

    // Misaligned redirect halts fetch until an aligned redirect.
    flush_to(32'h102);
    for (int i = 0; i < 10; i++) begin
      sample();
      check("halt_req", 32'(pm.PM_Req), 32'd0);
      check("halt_misal", 32'(Misaligned_IF), 32'd1);
    end
    check("halt_state", 32'(State_Dbg), 32'd2);
    flush_to(32'h200);
    sample();
    check("resume_misal", 32'(Misaligned_IF), 32'd0);
    check("resume_req", 32'(pm.PM_Req), 32'd1);
    check("resume_addr", pm.PM_Addr, 32'h200);
    wait_valid("resume_valid", 20);
    check("resume_pc", PC_IF, 32'h200);

    // Random grant, 1-4 cycle latency, random stall, periodic redirects.
    gnt_rand = 1'b1;
    lat_min = 1;
    lat_max = 4;
    n_pops = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      Stall_ID = ($urandom_range(0, 3) == 0);
      if (i % 97 == 50) begin
        Flush = 1'b1;
        Redirect_PC = 32'h1000 + 32'(i) * 32'd16;
      end else begin
        Flush = 1'b0;
      end
    end
    tick();
    Stall_ID = 1'b0;
    Flush = 1'b0;
    gnt_rand = 1'b0;
    repeat (10) sample();
    check("random_progress", 32'(n_pops > 40), 32'd1);

    // Reset mid-burst with one response outstanding; the stray response is ignored.
    lat_min = 3;
    lat_max = 3;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      sample();
      if (exp_q.size() == 1) begin
        ok = 1'b1;
        break;
      end
    end
    check("one_outstanding", 32'(ok), 32'd1);
    tick();
    Reset_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(pm.PM_Req), 32'd0);
    check("mid_rst_valid", 32'(Valid_IF), 32'd0);
    check("mid_rst_instr", Instruction_Fetch_IF_PM, NOP);
    check("mid_rst_pc", PC_IF, 32'h0);
    check("mid_rst_state", 32'(State_Dbg), 32'd0);
    repeat (2) sample();
    lat_min = 1;
    lat_max = 1;
    tick();
    Reset_n = 1'b1;
    wait_req("restart_req", 10);
    check("restart_addr", pm.PM_Addr, 32'h0);
    wait_valid("restart_valid", 20);
    check("restart_pc", PC_IF, 32'h0);
    check("restart_instr", Instruction_Fetch_IF_PM, mem_fn(32'h0));
    repeat (10) sample();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
